// File: rtl/mac_drain_pkg.sv
// rtl/mac_drain_pkg.sv - shared types and constants for the MAC drain path
//
// Purpose: FSM state type plus default parameter values and the index-width
// floor used by mac_drain, mac_drain_if and mac_drain_requant.
// Ports: none (package).
// Optional build macro used elsewhere in the slice: MAC_DRAIN_RELU_EN.
package mac_drain_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  localparam int unsigned DEF_N_MACS       = 4;
  localparam int unsigned DEF_ACC_WIDTH    = 32;
  localparam int unsigned DEF_OUTPUT_WIDTH = 16;
  localparam int unsigned DEF_OUTPUT_SCALE = 0;

  // Lane index counters are never narrower than one bit.
  localparam int unsigned IDX_W_MIN = 1;

endpackage

// File: rtl/mac_drain_if.sv
// rtl/mac_drain_if.sv - snapshot capture and result stream bundle for mac_drain
//
// Purpose: groups the accumulator capture handshake and the requantized
// result stream into one interface.
// Signals:
//   acc_in        N_MACS*ACC_WIDTH packed signed accumulators, lane 0 in LSBs
//   capture_valid snapshot of acc_in available
//   capture_ready drain can take a snapshot this cycle
//   out_data      requantized signed result
//   out_idx       lane index of out_data
//   out_last      beat for lane N_MACS-1
//   out_valid     out_data/out_idx/out_last valid
//   out_ready     downstream accepts the beat
//   busy          drain in progress
// Modports: slave (the drain block), master (MAC row + output writer side).
interface mac_drain_if
  import mac_drain_pkg::*;
#(
  parameter int unsigned N_MACS       = DEF_N_MACS,
  parameter int unsigned ACC_WIDTH    = DEF_ACC_WIDTH,
  parameter int unsigned OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
);

  localparam int unsigned IDX_W = (N_MACS > 1) ? $clog2(N_MACS) : IDX_W_MIN;

  logic [N_MACS*ACC_WIDTH-1:0] acc_in;
  logic                        capture_valid;
  logic                        capture_ready;
  logic [OUTPUT_WIDTH-1:0]     out_data;
  logic [IDX_W-1:0]            out_idx;
  logic                        out_last;
  logic                        out_valid;
  logic                        out_ready;
  logic                        busy;

  modport slave (
    input  acc_in,
    input  capture_valid,
    output capture_ready,
    output out_data,
    output out_idx,
    output out_last,
    output out_valid,
    input  out_ready,
    output busy
  );

  modport master (
    output acc_in,
    output capture_valid,
    input  capture_ready,
    input  out_data,
    input  out_idx,
    input  out_last,
    input  out_valid,
    output out_ready,
    input  busy
  );

endinterface

// File: rtl/mac_drain_requant.sv
// rtl/mac_drain_requant.sv - combinational round/shift/saturate (+ optional ReLU)
//
// Purpose: converts one signed ACC_WIDTH accumulator to a signed OUTPUT_WIDTH
// result: add half an LSB of the output scale, arithmetic shift right by
// OUTPUT_SCALE (round half up), saturate to the output range. With
// MAC_DRAIN_RELU_EN defined, negative results are forced to zero.
// Ports:
//   acc_in  in  ACC_WIDTH     signed accumulator value
//   q_out   out OUTPUT_WIDTH  requantized signed result
module mac_drain_requant
  import mac_drain_pkg::*;
#(
  parameter int unsigned ACC_WIDTH    = DEF_ACC_WIDTH,
  parameter int unsigned OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int unsigned OUTPUT_SCALE = DEF_OUTPUT_SCALE
) (
  input  logic [ACC_WIDTH-1:0]    acc_in,
  output logic [OUTPUT_WIDTH-1:0] q_out
);

  // One guard bit keeps the rounding add from wrapping at the positive end.
  localparam int unsigned EXT = ACC_WIDTH + 1;

  // 2^(OUTPUT_SCALE-1), which collapses to 0 when OUTPUT_SCALE is 0 so the
  // same datapath serves the pass-through case.
  localparam logic signed [EXT-1:0] HALF = (EXT'(1) << OUTPUT_SCALE) >> 1;

  localparam logic signed [EXT-1:0] SAT_MAX = EXT'((64'sd1 <<< (OUTPUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [EXT-1:0] SAT_MIN = -SAT_MAX - EXT'(1);

  logic signed [EXT-1:0]   ext_val;
  logic signed [EXT-1:0]   shifted;
  logic [OUTPUT_WIDTH-1:0] sat_val;

  always_comb begin
    ext_val = {acc_in[ACC_WIDTH-1], acc_in};
    shifted = (ext_val + HALF) >>> OUTPUT_SCALE;

    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[OUTPUT_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[OUTPUT_WIDTH-1:0];
    end else begin
      sat_val = shifted[OUTPUT_WIDTH-1:0];
    end

`ifdef MAC_DRAIN_RELU_EN
    q_out = sat_val[OUTPUT_WIDTH-1] ? '0 : sat_val;
`else
    q_out = sat_val;
`endif
  end

endmodule

// File: rtl/mac_drain.sv
// rtl/mac_drain.sv - MAC accumulator snapshot capture and requantized drain
//
// Purpose: latches N_MACS accumulators in one cycle (freeing the MAC row),
// then streams the requantized lanes one per cycle, lane 0 first. A new
// snapshot may be taken on the last-beat transfer so sustained throughput is
// one snapshot every N_MACS cycles with no out_valid bubble.
// Ports:
//   clk     in  clock
//   rst_in  in  synchronous active-high reset
//   bus     mac_drain_if.slave (capture handshake, result stream, busy)
// Build option: MAC_DRAIN_RELU_EN clamps negative results to zero
// (inside mac_drain_requant); ports and timing are unchanged.
module mac_drain
  import mac_drain_pkg::*;
#(
  parameter int unsigned N_MACS       = DEF_N_MACS,
  parameter int unsigned ACC_WIDTH    = DEF_ACC_WIDTH,
  parameter int unsigned OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int unsigned OUTPUT_SCALE = DEF_OUTPUT_SCALE
) (
  input logic        clk,
  input logic        rst_in,
  mac_drain_if.slave bus
);

  localparam int unsigned IDX_W = (N_MACS > 1) ? $clog2(N_MACS) : IDX_W_MIN;

  drain_state_t                          state_q, state_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic [N_MACS-1:0][ACC_WIDTH-1:0]      snap_q, snap_d;

  logic                    idx_is_last;
  logic                    out_valid;
  logic                    cap_ready;
  logic [ACC_WIDTH-1:0]    lane_val;
  logic [OUTPUT_WIDTH-1:0] q_data;

  assign idx_is_last = (idx_q == IDX_W'(N_MACS - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    cap_ready = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        cap_ready = 1'b1;
        if (bus.capture_valid) begin
          snap_d  = bus.acc_in;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          if (idx_is_last) begin
            // Last beat leaving: the snapshot register is free this very
            // cycle, so a waiting capture is taken without a bubble.
            cap_ready = 1'b1;
            idx_d     = '0;
            if (bus.capture_valid) begin
              snap_d = bus.acc_in;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  assign lane_val = snap_q[idx_q];

  mac_drain_requant #(
    .ACC_WIDTH    (ACC_WIDTH),
    .OUTPUT_WIDTH (OUTPUT_WIDTH),
    .OUTPUT_SCALE (OUTPUT_SCALE)
  ) u_requant (
    .acc_in (lane_val),
    .q_out  (q_data)
  );

  // Outputs read as zero whenever no beat is being offered.
  assign bus.capture_ready = cap_ready;
  assign bus.out_valid     = out_valid;
  assign bus.out_data      = out_valid ? q_data : '0;
  assign bus.out_idx       = idx_q;
  assign bus.out_last      = out_valid & idx_is_last;
  assign bus.busy          = (state_q == DRAIN);

endmodule

// File: tb/tb_mac_drain.sv
// tb/tb_mac_drain.sv - self-checking bench for mac_drain (scale 0 and scale 4)
module tb_mac_drain;

  localparam int N   = 4;
  localparam int ACW = 32;
  localparam int OW  = 16;

  logic clk = 1'b0;
  logic rst_in;
  always #5 clk = ~clk;

  mac_drain_if #(.N_MACS(N), .ACC_WIDTH(ACW), .OUTPUT_WIDTH(OW)) bus0 ();
  mac_drain_if #(.N_MACS(N), .ACC_WIDTH(ACW), .OUTPUT_WIDTH(OW)) bus4 ();

  mac_drain #(.N_MACS(N), .ACC_WIDTH(ACW), .OUTPUT_WIDTH(OW), .OUTPUT_SCALE(0)) dut0 (
    .clk    (clk),
    .rst_in (rst_in),
    .bus    (bus0)
  );

  mac_drain #(.N_MACS(N), .ACC_WIDTH(ACW), .OUTPUT_WIDTH(OW), .OUTPUT_SCALE(4)) dut4 (
    .clk    (clk),
    .rst_in (rst_in),
    .bus    (bus4)
  );

  // Reference: the raw lane values of the snapshot still to be streamed.
  longint pending[$];
  bit     after_rst;
  int     total;
  int     bad;

  function automatic logic [15:0] ref_q(input longint v, input int s);
    longint r;
    r = v;
    if (s > 0) r = (v + (longint'(1) <<< (s - 1))) >>> s;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`ifdef MAC_DRAIN_RELU_EN
    if (r < 0) r = 0;
`endif
    return 16'(r);
  endfunction

  function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
    logic [127:0] p;
    p[31:0]   = a;
    p[63:32]  = b;
    p[95:64]  = c;
    p[127:96] = d;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_dut(input string nm, input int s, input logic ordy,
                         input logic v, input logic cr, input logic b, input logic l,
                         input logic [1:0] idx, input logic [15:0] d);
    int n;
    n = pending.size();
    chk({nm, ".out_valid"}, {31'd0, v}, {31'd0, n > 0});
    chk({nm, ".capture_ready"}, {31'd0, cr}, {31'd0, (n == 0) || (n == 1 && ordy)});
    chk({nm, ".busy"}, {31'd0, b}, {31'd0, n > 0});
    if (n > 0) begin
      chk({nm, ".out_idx"}, {30'd0, idx}, 32'(N - n));
      chk({nm, ".out_last"}, {31'd0, l}, {31'd0, n == 1});
      chk({nm, ".out_data"}, {16'd0, d}, {16'd0, ref_q(pending[0], s)});
    end else if (after_rst) begin
      chk({nm, ".rst_out_idx"}, {30'd0, idx}, 32'd0);
      chk({nm, ".rst_out_last"}, {31'd0, l}, 32'd0);
      chk({nm, ".rst_out_data"}, {16'd0, d}, 32'd0);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check settled outputs,
  // advance the reference, then wait for the edge that consumes the inputs.
  task automatic step(input logic rst, input logic cv, input logic [127:0] acc, input logic ordy);
    logic cr_exp;
    rst_in             = rst;
    bus0.capture_valid = cv;
    bus4.capture_valid = cv;
    bus0.acc_in        = acc;
    bus4.acc_in        = acc;
    bus0.out_ready     = ordy;
    bus4.out_ready     = ordy;
    #2;
    chk_dut("s0", 0, ordy, bus0.out_valid, bus0.capture_ready, bus0.busy,
            bus0.out_last, bus0.out_idx, bus0.out_data);
    chk_dut("s4", 4, ordy, bus4.out_valid, bus4.capture_ready, bus4.busy,
            bus4.out_last, bus4.out_idx, bus4.out_data);
    if (rst) begin
      pending.delete();
      after_rst = 1'b1;
    end else begin
      cr_exp = (pending.size() == 0) || (pending.size() == 1 && ordy);
      if (pending.size() > 0 && ordy) void'(pending.pop_front());
      if (cv && cr_exp) begin
        for (int i = 0; i < N; i++) pending.push_back(longint'($signed(acc[i*32 +: 32])));
        after_rst = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int rand_lane();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 400)) - 200;
      1: return int'($urandom);
      2: return 32'h7FFF_FFF0 + int'($urandom_range(0, 15));
      default: return int'($urandom_range(0, 2000000)) - 1000000;
    endcase
  endfunction

  initial begin
    logic [127:0] a;
    logic [127:0] b;
    total     = 0;
    bad       = 0;
    after_rst = 1'b0;
    rst_in    = 1'b1;
    bus0.capture_valid = 1'b0;
    bus4.capture_valid = 1'b0;
    bus0.acc_in = '0;
    bus4.acc_in = '0;
    bus0.out_ready = 1'b0;
    bus4.out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);

    // Basic drain: 5, -7, 100, 0.
    a = pack4(5, -7, 100, 0);
    step(1'b0, 1'b1, a, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Backpressure on lane 1 for three cycles.
    step(1'b0, 1'b1, a, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, pack4(9, 9, 9, 9), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Back-to-back snapshots: capture held high on the last beat.
    b = pack4(-3, 3, 1000, -1000);
    step(1'b0, 1'b1, a, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, b, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Rounding and saturation corners, plus ReLU-relevant signs.
    step(1'b0, 1'b1, pack4(24, -24, 32'h7FFF_FFFF, 32'h8000_0000), 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, pack4(-7, 3, 8, -8), 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Reset while lane 2 is on the bus; remaining beats must vanish.
    step(1'b0, 1'b1, a, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      a = pack4(rand_lane(), rand_lane(), rand_lane(), rand_lane());
      step($urandom_range(0, 60) == 0, $urandom_range(0, 1) == 1, a,
           $urandom_range(0, 9) < 7);
    end

    // Drain whatever is left, bounded.
    for (int i = 0; i < 10 && pending.size() > 0; i++) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
